// File: rtl/fetch_prefetch_queue_if.sv
// Fetch/IF-ID bus bundle for fetch_prefetch_queue.
//   imem_addr/imem_rd/imem_data : instruction memory fetch port (data returns 1 cycle after rd)
//   redirect/redirect_pc        : branch/jump flush request from ID
//   halt                        : freeze issue and dequeue
//   out_valid/out_ready         : IF/ID handshake; out_instr/out_pc carry the head entry
//   count                       : occupied queue entries
// master = the prefetch queue, slave = the memory/decode environment.
interface fetch_prefetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [15:0]   imem_addr;
  logic          imem_rd;
  logic [15:0]   imem_data;
  logic          redirect;
  logic [15:0]   redirect_pc;
  logic          halt;
  logic          out_ready;
  logic          out_valid;
  logic [15:0]   out_instr;
  logic [15:0]   out_pc;
  logic [CW-1:0] count;

  modport master (
    output imem_addr, imem_rd, out_valid, out_instr, out_pc, count,
    input  imem_data, redirect, redirect_pc, halt, out_ready
  );

  modport slave (
    input  imem_addr, imem_rd, out_valid, out_instr, out_pc, count,
    output imem_data, redirect, redirect_pc, halt, out_ready
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch buffer between instruction memory and the IF/ID register.
// Issues sequential fetches, buffers returned words with their PC+PC_INC in a
// DEPTH-entry FIFO and presents the head with a valid/ready handshake.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : fetch_prefetch_queue_if.master (memory port, redirect, halt, IF/ID handshake, count)
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'h0002
) (
  input logic                    clk,
  input logic                    rst,
  fetch_prefetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t        state_q, state_d;
  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic [15:0]   inflight_pc_q, inflight_pc_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;

  logic [15:0]   instr_mem [DEPTH];
  logic [15:0]   pc_mem    [DEPTH];

  logic          flush;
  logic          issue;
  logic          push;
  logic          pop;
  logic          valid;
  logic [CW:0]   occupancy;

  // Redirect is ignored in BOOT; nothing is buffered or in flight there.
  assign flush     = bus.redirect & (state_q != BOOT);
  // Reserve a slot for the word still in flight so the FIFO can never overflow.
  assign occupancy = {1'b0, count_q} + (CW+1)'(inflight_q);
  assign issue     = (state_q == RUN) & ~bus.halt & ~bus.redirect
                     & (occupancy < (CW+1)'(DEPTH));
  // The return is pushed even while halted so no fetched word is lost.
  assign push      = inflight_q & ~flush;
  assign valid     = (count_q != '0) & ~bus.halt;
  assign pop       = valid & bus.out_ready & ~flush;

  assign bus.imem_addr = fetch_pc_q;
  assign bus.imem_rd   = issue;
  assign bus.out_valid = valid;
  assign bus.out_instr = (count_q == '0) ? '0 : instr_mem[rd_ptr_q];
  assign bus.out_pc    = (count_q == '0) ? '0 : pc_mem[rd_ptr_q];
  assign bus.count     = count_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = bus.halt ? HALTED : RUN;
      RUN:     if (bus.halt)  state_d = HALTED;
      HALTED:  if (!bus.halt) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    if (flush) begin
      fetch_pc_d = bus.redirect_pc;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + PC_INC;
        inflight_pc_d = fetch_pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= bus.imem_data;
      pc_mem[wr_ptr_q]    <= inflight_pc_q + PC_INC;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
module tb_fetch_prefetch_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_prefetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(16'h0000),
    .PC_INC  (16'h0002)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int nchecks = 0;
  int nerrors = 0;
  int cyc     = 0;

  // Memory contents: simple pattern for directed tests, scrambled for random.
  bit scramble = 1'b0;
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    logic [15:0] s;
    s = {a[7:0], a[15:8]} ^ 16'h5A5A;
    return scramble ? s : (16'hA000 | a);
  endfunction

  always @(posedge clk) if (bus.imem_rd) bus.imem_data <= mem_fn(bus.imem_addr);

  // Reference model: queue of delivered words plus one outstanding fetch.
  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } ent_t;
  ent_t        mq[$];
  bit          m_infl;
  logic [15:0] m_ipc;
  logic [15:0] m_fpc;
  bit          m_booted;
  bit          m_prev_halt;
  bit          m_ev;
  bit          m_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s cyc=%0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_model();
    logic [15:0] ei, ep;
    m_ev = (mq.size() > 0) && !bus.halt;
    // Issue needs a completed boot cycle, halt low now and in the previous cycle,
    // no redirect and a free slot counting the outstanding fetch.
    m_rd = m_booted && !m_prev_halt && !bus.halt && !bus.redirect
           && (mq.size() + int'(m_infl) < DEPTH);
    ei = (mq.size() > 0) ? mq[0].instr : 16'h0000;
    ep = (mq.size() > 0) ? mq[0].pc    : 16'h0000;
    chk("m_valid", bus.out_valid, m_ev);
    chk("m_instr", bus.out_instr, ei);
    chk("m_pc",    bus.out_pc,    ep);
    chk("m_count", bus.count,     mq.size());
    chk("m_rd",    bus.imem_rd,   m_rd);
    if (m_rd) chk("m_addr", bus.imem_addr, m_fpc);
  endtask

  task automatic model_update();
    if (bus.redirect && m_booted) begin
      mq.delete();
      m_infl = 1'b0;
      m_fpc  = bus.redirect_pc;
    end else begin
      if (m_ev && bus.out_ready) void'(mq.pop_front());
      if (m_infl) mq.push_back('{pc: m_ipc + 16'd2, instr: mem_fn(m_ipc)});
      if (m_rd) begin
        m_infl = 1'b1;
        m_ipc  = m_fpc;
        m_fpc  = m_fpc + 16'd2;
      end else begin
        m_infl = 1'b0;
      end
    end
    m_prev_halt = bus.halt;
    m_booted    = 1'b1;
  endtask

  // Called at posedge+1: apply inputs, settle, compare against the model.
  task automatic drive(input bit h, input bit rdy, input bit rdr, input logic [15:0] rp);
    bus.halt        = h;
    bus.out_ready   = rdy;
    bus.redirect    = rdr;
    bus.redirect_pc = rp;
    #2;
    check_model();
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asynchronous reset assertion; returns at posedge+1 at the start of the BOOT cycle.
  task automatic do_reset();
    rst = 1'b0;
    bus.halt = 1'b0; bus.redirect = 1'b0; bus.out_ready = 1'b0; bus.redirect_pc = '0;
    mq.delete();
    m_infl = 1'b0; m_ipc = '0; m_fpc = 16'h0000; m_booted = 1'b0; m_prev_halt = 1'b0;
    #1;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_count", bus.count,     3'd0);
    chk("rst_rd",    bus.imem_rd,   1'b0);
    chk("rst_addr",  bus.imem_addr, 16'h0000);
    chk("rst_instr", bus.out_instr, 16'h0000);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    cyc = 0;
  endtask

  typedef struct {
    bit          halt;
    bit          ready;
    bit          redir;
    logic [15:0] rpc;
    bit          ev;
    logic [15:0] ei;
    logic [15:0] ep;
    bit          erd;
    logic [15:0] ea;
    logic [2:0]  ec;
  } vec_t;
  vec_t t1[6];

  task automatic run_table();
    for (int i = 0; i < 6; i++) begin
      drive(t1[i].halt, t1[i].ready, t1[i].redir, t1[i].rpc);
      chk("t_valid", bus.out_valid, t1[i].ev);
      chk("t_instr", bus.out_instr, t1[i].ei);
      chk("t_pc",    bus.out_pc,    t1[i].ep);
      chk("t_rd",    bus.imem_rd,   t1[i].erd);
      chk("t_addr",  bus.imem_addr, t1[i].ea);
      chk("t_count", bus.count,     t1[i].ec);
      tick();
    end
  endtask

  initial begin
    logic [15:0] exp_addr[3];
    logic [15:0] exp_opc[3];
    logic [15:0] rp;
    bit          h;

    t1[0] = '{1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 3'd0};
    t1[1] = '{1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 3'd0};
    t1[2] = '{1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0002, 3'd0};
    t1[3] = '{1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'hA000, 16'h0002, 1'b1, 16'h0004, 3'd1};
    t1[4] = '{1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'hA002, 16'h0004, 1'b1, 16'h0006, 3'd1};
    t1[5] = '{1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'hA004, 16'h0006, 1'b1, 16'h0008, 3'd1};
    exp_addr = '{16'hFFFC, 16'hFFFE, 16'h0000};
    exp_opc  = '{16'hFFFE, 16'h0000, 16'h0002};

    #1;
    // Startup sequence and steady streaming.
    do_reset();
    run_table();

    // Back-pressure until full, then drain in order.
    do_reset();
    repeat (8) begin drive(0, 0, 0, 0); tick(); end
    drive(0, 0, 0, 0);
    chk("full_count", bus.count,   3'd4);
    chk("full_rd",    bus.imem_rd, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0);
      chk("drain_valid", bus.out_valid, 1'b1);
      chk("drain_instr", bus.out_instr, 16'hA000 + 16'(2 * i));
      if (i == 1) begin
        chk("resume_rd",   bus.imem_rd,   1'b1);
        chk("resume_addr", bus.imem_addr, 16'h0008);
      end
      tick();
    end

    // Redirect with three buffered words and one in flight.
    do_reset();
    repeat (5) begin drive(0, 0, 0, 0); tick(); end
    drive(0, 0, 1, 16'h0040);
    chk("redir_pre_count", bus.count,   3'd3);
    chk("redir_rd",        bus.imem_rd, 1'b0);
    tick();
    drive(0, 1, 0, 0);
    chk("redir_count", bus.count,     3'd0);
    chk("redir_valid", bus.out_valid, 1'b0);
    chk("redir_rd1",   bus.imem_rd,   1'b1);
    chk("redir_addr",  bus.imem_addr, 16'h0040);
    tick();
    drive(0, 1, 0, 0);
    chk("redir_stale", bus.out_valid, 1'b0);
    tick();
    drive(0, 1, 0, 0);
    chk("redir_out_valid", bus.out_valid, 1'b1);
    chk("redir_out_instr", bus.out_instr, 16'hA040);
    chk("redir_out_pc",    bus.out_pc,    16'h0042);
    tick();

    // Halt with two buffered words and one in flight.
    do_reset();
    repeat (4) begin drive(0, 0, 0, 0); tick(); end
    drive(1, 1, 0, 0);
    chk("halt_pre_count", bus.count,     3'd2);
    chk("halt_valid",     bus.out_valid, 1'b0);
    chk("halt_rd",        bus.imem_rd,   1'b0);
    tick();
    drive(1, 1, 0, 0);
    chk("halt_count", bus.count,     3'd3);
    chk("halt_valid2", bus.out_valid, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0);
      chk("unhalt_valid", bus.out_valid, 1'b1);
      chk("unhalt_instr", bus.out_instr, 16'hA000 + 16'(2 * i));
      tick();
    end

    // Address wrap.
    drive(0, 1, 1, 16'hFFFC);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0);
      if (i < 3) begin
        chk("wrap_rd",   bus.imem_rd,   1'b1);
        chk("wrap_addr", bus.imem_addr, exp_addr[i]);
      end
      if (i >= 2) chk("wrap_out_pc", bus.out_pc, exp_opc[i-2]);
      tick();
    end

    // Asynchronous reset mid-stream, then a clean restart.
    do_reset();
    repeat (4) begin drive(0, 0, 0, 0); tick(); end
    drive(0, 0, 0, 0);
    chk("arst_pre_count", bus.count, 3'd2);
    do_reset();
    run_table();

    // Randomized traffic against the model.
    scramble = 1'b1;
    do_reset();
    h = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) h = ~h;
      rp = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 1) == 0) rp = 16'hFFF0 | rp[3:0];
      rp[0] = 1'b0;
      drive(h, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, rp);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
